// File: rtl/spi_proto_pkg.sv
// Shared constants and state encoding for the 4-bit-command SPI protocol.
package spi_proto_pkg;

  localparam logic [3:0] CMD_READ  = 4'b1010;
  localparam logic [3:0] CMD_WRITE = 4'b1011;

  localparam int CMD_BITS      = 4;
  localparam int ADDR_BITS     = 4;
  localparam int DUMMY_CLKS    = 2;
  localparam int DATA_MAX_BITS = 16;

  localparam logic [3:0] STATUS_ADDR = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Pin synchronizer with rise/fall detection; one instance per SPI pin.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI target responder serving a 16x16 register file, oversampled on clk_i.
// Optional SPI_RESP_STATUS_EN: address 15 becomes a read-only {err_cnt, wr_cnt} status word.
//   state      | meaning
//   ST_IDLE    | waiting for CS fall
//   ST_CMD     | shifting in 4-bit command
//   ST_ADDR    | shifting in 4-bit address
//   ST_DUMMY   | two ignored clocks
//   ST_WR_DATA | collecting up to 16 write bits
//   ST_RD_DATA | shifting out read word
//   ST_IGNORE  | illegal command, wait for CS rise
import spi_proto_pkg::*;

module spi_slave_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spi_clk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o,
  output logic        wr_vld_o,
  output logic [3:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        err_o,
  input  logic [3:0]  loc_addr_i,
  output logic [15:0] loc_rdata_o
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pin_i(spi_clk_i),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pin_i(spi_cs_n_i),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pin_i(spi_sdi_i),
    .level_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, cs_lvl, sdi_rise, sdi_fall};

  spi_state_e  state_q;
  logic [4:0]  bit_cnt_q;
  logic [3:0]  cmd_q, addr_q;
  logic        is_rd_q;
  logic [15:0] rx_q, tx_q;
  logic [15:0] regs_q [16];

  logic [3:0]  cmd_shift, addr_shift;
  logic [15:0] wr_word, spi_rword;
  logic        wr_blocked;

  assign cmd_shift  = {cmd_q[2:0], sdi_lvl};
  assign addr_shift = {addr_q[2:0], sdi_lvl};
  // Partial writes are left-aligned; n is never 0 where this is used.
  assign wr_word    = rx_q << (5'd16 - bit_cnt_q);

`ifdef SPI_RESP_STATUS_EN
  logic [7:0]  wr_cnt_q, err_cnt_q;
  logic [15:0] status_word;
  assign status_word = {err_cnt_q, wr_cnt_q};
  assign wr_blocked  = (addr_q == STATUS_ADDR);
`else
  assign wr_blocked  = 1'b0;
`endif

  always_comb begin
    loc_rdata_o = regs_q[loc_addr_i];
    spi_rword   = regs_q[addr_shift];
`ifdef SPI_RESP_STATUS_EN
    if (loc_addr_i == STATUS_ADDR) loc_rdata_o = status_word;
    if (addr_shift == STATUS_ADDR) spi_rword = status_word;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      is_rd_q      <= 1'b0;
      rx_q         <= '0;
      tx_q         <= '0;
      spi_sdo_o    <= 1'b0;
      spi_sdo_oe_o <= 1'b0;
      wr_vld_o     <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      err_o        <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
`ifdef SPI_RESP_STATUS_EN
      wr_cnt_q     <= '0;
      err_cnt_q    <= '0;
`endif
    end else begin
      wr_vld_o <= 1'b0;
      err_o    <= 1'b0;
      if (cs_fall) begin
        state_q      <= ST_CMD;
        bit_cnt_q    <= '0;
        spi_sdo_o    <= 1'b0;
        spi_sdo_oe_o <= 1'b0;
      end else if (cs_rise) begin
        state_q      <= ST_IDLE;
        spi_sdo_o    <= 1'b0;
        spi_sdo_oe_o <= 1'b0;
        case (state_q)
          ST_WR_DATA: begin
            if (bit_cnt_q != 5'd0) begin
              if (wr_blocked) begin
                err_o <= 1'b1;
              end else begin
                regs_q[addr_q] <= wr_word;
                wr_vld_o       <= 1'b1;
                wr_addr_o      <= addr_q;
                wr_data_o      <= wr_word;
`ifdef SPI_RESP_STATUS_EN
                wr_cnt_q       <= wr_cnt_q + 8'd1;
`endif
              end
            end
          end
          ST_CMD, ST_ADDR, ST_DUMMY: begin
            err_o <= 1'b1;
`ifdef SPI_RESP_STATUS_EN
            err_cnt_q <= err_cnt_q + 8'd1;
`endif
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_CMD: if (sclk_rise) begin
            cmd_q <= cmd_shift;
            if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
              bit_cnt_q <= '0;
              if (cmd_shift == CMD_READ || cmd_shift == CMD_WRITE) begin
                is_rd_q <= (cmd_shift == CMD_READ);
                state_q <= ST_ADDR;
              end else begin
                err_o   <= 1'b1;
                state_q <= ST_IGNORE;
`ifdef SPI_RESP_STATUS_EN
                err_cnt_q <= err_cnt_q + 8'd1;
`endif
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
          ST_ADDR: if (sclk_rise) begin
            addr_q <= addr_shift;
            if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DUMMY;
              if (is_rd_q) tx_q <= spi_rword;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
          ST_DUMMY: if (sclk_rise) begin
            if (bit_cnt_q == 5'(DUMMY_CLKS - 1)) begin
              bit_cnt_q <= '0;
              rx_q      <= '0;
              state_q   <= is_rd_q ? ST_RD_DATA : ST_WR_DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
          ST_WR_DATA: if (sclk_rise && bit_cnt_q < 5'(DATA_MAX_BITS)) begin
            rx_q      <= {rx_q[14:0], sdi_lvl};
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
          ST_RD_DATA: if (sclk_fall) begin
            spi_sdo_oe_o <= 1'b1;
            if (bit_cnt_q < 5'(DATA_MAX_BITS)) begin
              spi_sdo_o <= tx_q[15];
              tx_q      <= {tx_q[14:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
              spi_sdo_o <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
